// File: rtl/code_entry_checker.sv
// Lock-code entry checker: compares a four-digit user entry (2-bit digits) against
// the generator code and tracks failed attempts, wrong-code dwell and lockout.
module code_entry_checker #(
    parameter int MAX_TRIES      = 3,
    parameter int FAIL_CYCLES    = 20,
    parameter int LOCKOUT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code,
    input  logic [1:0] digit,
    input  logic       enter,
    input  logic       clear,
    output logic       unlocked,
    output logic       wrong,
    output logic       locked_out,
    output logic [2:0] digit_count,
    output logic [1:0] attempts_left
);

    localparam int MAX_CYC = (FAIL_CYCLES > LOCKOUT_CYCLES) ? FAIL_CYCLES : LOCKOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [1:0]    TRIES_INIT   = MAX_TRIES[1:0];
    localparam logic [TW-1:0] FAIL_LOAD    = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ZERO   = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [2:0]    count_s;
    logic [1:0]    attempts_s;
    logic [7:0]    code_q_r, code_q_s;
    logic          mismatch_r, mismatch_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [1:0]    expected_s;
    logic          miss_s;

    // Digit n of a code, most significant pair first
    function automatic logic [1:0] code_digit(input logic [7:0] c, input logic [2:0] n);
        case (n)
            3'd0:    code_digit = c[7:6];
            3'd1:    code_digit = c[5:4];
            3'd2:    code_digit = c[3:2];
            3'd3:    code_digit = c[1:0];
            default: code_digit = 2'b00;
        endcase
    endfunction

    // Next-state and next-value logic for every register
    always_comb begin
        state_s    = state_r;
        count_s    = digit_count;
        attempts_s = attempts_left;
        code_q_s   = code_q_r;
        mismatch_s = mismatch_r;
        timer_s    = timer_r;
        // the first digit is checked against the live code as it is being latched
        if (digit_count == 3'd0) begin
            expected_s = code_digit(code, 3'd0);
        end else begin
            expected_s = code_digit(code_q_r, digit_count);
        end
        miss_s = mismatch_r | (digit != expected_s);

        case (state_r)
            ST_ENTRY: begin
                if (clear) begin
                    count_s    = 3'd0;
                    mismatch_s = 1'b0;
                end else if (enter) begin
                    if (digit_count == 3'd0) begin
                        code_q_s = code;
                    end else begin
                        code_q_s = code_q_r;
                    end
                    count_s = digit_count + 3'd1;
                    if (digit_count == 3'd3) begin
                        mismatch_s = 1'b0;
                        if (!miss_s) begin
                            state_s = ST_OPEN;
                        end else if (attempts_left > 2'd1) begin
                            state_s    = ST_FAIL;
                            attempts_s = attempts_left - 2'd1;
                            timer_s    = FAIL_LOAD;
                        end else begin
                            state_s    = ST_LOCKOUT;
                            attempts_s = 2'd0;
                            timer_s    = LOCKOUT_LOAD;
                        end
                    end else begin
                        mismatch_s = miss_s;
                    end
                end else begin
                    count_s = digit_count;
                end
            end
            ST_OPEN: begin
                if (clear) begin
                    state_s    = ST_ENTRY;
                    count_s    = 3'd0;
                    attempts_s = TRIES_INIT;
                end else begin
                    state_s = ST_OPEN;
                end
            end
            ST_FAIL: begin
                if (timer_r == TIMER_ZERO) begin
                    state_s = ST_ENTRY;
                    count_s = 3'd0;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_LOCKOUT: begin
                if (timer_r == TIMER_ZERO) begin
                    state_s    = ST_ENTRY;
                    count_s    = 3'd0;
                    attempts_s = TRIES_INIT;
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            default: begin
                state_s    = ST_ENTRY;
                count_s    = 3'd0;
                attempts_s = TRIES_INIT;
                mismatch_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_ENTRY;
            digit_count   <= 3'd0;
            attempts_left <= TRIES_INIT;
            code_q_r      <= 8'h00;
            mismatch_r    <= 1'b0;
            timer_r       <= TIMER_ZERO;
            unlocked      <= 1'b0;
            wrong         <= 1'b0;
            locked_out    <= 1'b0;
        end else begin
            state_r       <= state_s;
            digit_count   <= count_s;
            attempts_left <= attempts_s;
            code_q_r      <= code_q_s;
            mismatch_r    <= mismatch_s;
            timer_r       <= timer_s;
            unlocked      <= (state_s == ST_OPEN);
            wrong         <= (state_s == ST_FAIL);
            locked_out    <= (state_s == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_code_entry_checker.sv
// Directed self-checking bench for code_entry_checker with default parameters.
module tb_code_entry_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] code = 8'b10_01_11_00;
    logic [1:0] digit = 2'd0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       unlocked, wrong, locked_out;
    logic [2:0] digit_count;
    logic [1:0] attempts_left;

    int n_checks = 0;
    int n_fail = 0;

    code_entry_checker dut (
        .clk(clk), .reset(reset), .code(code), .digit(digit), .enter(enter),
        .clear(clear), .unlocked(unlocked), .wrong(wrong), .locked_out(locked_out),
        .digit_count(digit_count), .attempts_left(attempts_left)
    );

    always #5 clk = ~clk;

    task automatic do_enter(input logic [1:0] d);
        digit = d;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({unlocked, wrong, locked_out} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b exp 000", {unlocked, wrong, locked_out});
        end
        n_checks++;
        if (digit_count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count got %0d exp 0", digit_count);
        end
        n_checks++;
        if (attempts_left !== 2'd3) begin
            n_fail++; $display("FAIL reset_attempts got %0d exp 3", attempts_left);
        end
    endtask

    task automatic test_correct_code();
        do_enter(2'd2);
        do_enter(2'd1);
        n_checks++;
        if (digit_count !== 3'd2) begin
            n_fail++; $display("FAIL partial_count got %0d exp 2", digit_count);
        end
        do_enter(2'd3);
        do_enter(2'd0);
        n_checks++;
        if ({unlocked, wrong, locked_out, digit_count, attempts_left} !== {3'b100, 3'd4, 2'd3}) begin
            n_fail++; $display("FAIL open_state got u%b w%b l%b c%0d a%0d exp u1 w0 l0 c4 a3",
                               unlocked, wrong, locked_out, digit_count, attempts_left);
        end
        do_enter(2'd1);
        n_checks++;
        if ({unlocked, digit_count} !== {1'b1, 3'd4}) begin
            n_fail++; $display("FAIL open_ignores_enter got u%b c%0d exp u1 c4", unlocked, digit_count);
        end
        do_clear();
        n_checks++;
        if ({unlocked, digit_count, attempts_left} !== {1'b0, 3'd0, 2'd3}) begin
            n_fail++; $display("FAIL open_clear got u%b c%0d a%0d exp u0 c0 a3",
                               unlocked, digit_count, attempts_left);
        end
    endtask

    task automatic test_single_wrong();
        int cnt;
        do_enter(2'd2); do_enter(2'd1); do_enter(2'd3); do_enter(2'd1);
        n_checks++;
        if ({wrong, digit_count, attempts_left} !== {1'b1, 3'd4, 2'd2}) begin
            n_fail++; $display("FAIL fail_entry got w%b c%0d a%0d exp w1 c4 a2",
                               wrong, digit_count, attempts_left);
        end
        cnt = 0;
        while (wrong && cnt < 200) begin
            cnt++;
            clear = (cnt == 3);
            @(negedge clk);
            clear = 1'b0;
        end
        n_checks++;
        if (cnt !== 20) begin
            n_fail++; $display("FAIL fail_dwell got %0d exp 20", cnt);
        end
        n_checks++;
        if ({digit_count, attempts_left} !== {3'd0, 2'd2}) begin
            n_fail++; $display("FAIL fail_exit got c%0d a%0d exp c0 a2", digit_count, attempts_left);
        end
        do_enter(2'd2); do_enter(2'd1); do_enter(2'd3); do_enter(2'd0);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++; $display("FAIL unlock_after_fail got %b exp 1", unlocked);
        end
        do_clear();
    endtask

    task automatic test_lockout();
        int cnt;
        for (int t = 0; t < 2; t++) begin
            do_enter(2'd0); do_enter(2'd1); do_enter(2'd3); do_enter(2'd0);
            cnt = 0;
            while (wrong && cnt < 200) begin
                cnt++;
                @(negedge clk);
            end
        end
        n_checks++;
        if (attempts_left !== 2'd1) begin
            n_fail++; $display("FAIL attempts_before_lock got %0d exp 1", attempts_left);
        end
        do_enter(2'd2); do_enter(2'd1); do_enter(2'd0); do_enter(2'd0);
        n_checks++;
        if ({locked_out, wrong, attempts_left} !== {1'b1, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL lock_entry got l%b w%b a%0d exp l1 w0 a0",
                               locked_out, wrong, attempts_left);
        end
        cnt = 0;
        while (locked_out && cnt < 300) begin
            cnt++;
            digit = 2'd2;
            enter = (cnt % 10 == 5);
            clear = (cnt % 10 == 7);
            @(negedge clk);
            enter = 1'b0;
            clear = 1'b0;
        end
        n_checks++;
        if (cnt !== 100) begin
            n_fail++; $display("FAIL lock_dwell got %0d exp 100", cnt);
        end
        n_checks++;
        if ({digit_count, attempts_left} !== {3'd0, 2'd3}) begin
            n_fail++; $display("FAIL lock_exit got c%0d a%0d exp c0 a3", digit_count, attempts_left);
        end
    endtask

    task automatic test_clear_mid_entry();
        do_enter(2'd2); do_enter(2'd1);
        do_clear();
        n_checks++;
        if ({digit_count, attempts_left} !== {3'd0, 2'd3}) begin
            n_fail++; $display("FAIL clear_mid got c%0d a%0d exp c0 a3", digit_count, attempts_left);
        end
        digit = 2'd2; enter = 1'b1; clear = 1'b1;
        @(negedge clk);
        enter = 1'b0; clear = 1'b0;
        n_checks++;
        if (digit_count !== 3'd0) begin
            n_fail++; $display("FAIL enter_clear_same got %0d exp 0", digit_count);
        end
        do_enter(2'd2); do_enter(2'd1); do_enter(2'd3); do_enter(2'd0);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++; $display("FAIL unlock_after_clear got %b exp 1", unlocked);
        end
        do_clear();
    endtask

    task automatic test_code_latched();
        do_enter(2'd2);
        code = 8'hFF;
        do_enter(2'd1); do_enter(2'd3); do_enter(2'd0);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++; $display("FAIL code_latched got %b exp 1", unlocked);
        end
        do_clear();
        code = 8'b10_01_11_00;
    endtask

    task automatic test_async_reset();
        do_enter(2'd2); do_enter(2'd1); do_enter(2'd3); do_enter(2'd1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (wrong !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_wrong got %b exp 1", wrong);
        end
        #2 reset = 1'b1;
        code = 8'b00_11_01_10;
        #1;
        n_checks++;
        if ({unlocked, wrong, locked_out, digit_count, attempts_left} !== {3'b000, 3'd0, 2'd3}) begin
            n_fail++; $display("FAIL async_reset got u%b w%b l%b c%0d a%0d exp u0 w0 l0 c0 a3",
                               unlocked, wrong, locked_out, digit_count, attempts_left);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_enter(2'd0); do_enter(2'd3); do_enter(2'd1); do_enter(2'd2);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++; $display("FAIL new_code_after_reset got %b exp 1", unlocked);
        end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_single_wrong();
        test_lockout();
        test_clear_mid_entry();
        test_code_latched();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/code_entry_checker.md
# code_entry_checker

Consumes the 8-bit lock code produced by the code generator and checks it against a 4-digit user entry. Each digit is 2 bits (0–3), so the code holds four digits: `code[7:6]` first through `code[1:0]` last. The block tracks failed attempts, reports open, wrong and lockout conditions, and sits between the generator and the display and LED drivers.

## Interface
- `MAX_TRIES`, default 3: failed attempts allowed before lockout. Legal range 1–3.
- `FAIL_CYCLES`, default 20: cycles that `wrong` stays high after a bad entry. Must be ≥1.
- `LOCKOUT_CYCLES`, default 100: cycles spent in lockout. Must be ≥1.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `code` in 8: target code from the generator.
- `digit` in 2: current digit value from the switches.
- `enter` in 1: single-cycle pulse, already synchronised and edge-detected upstream. Commits `digit`.
- `clear` in 1: single-cycle pulse. Aborts a partial entry, or relocks after an open.
- `unlocked` out 1: high while in OPEN.
- `wrong` out 1: high while in FAIL.
- `locked_out` out 1: high while in LOCKOUT.
- `digit_count` out 3: digits committed in the current entry, 0–4.
- `attempts_left` out 2: remaining tries.

## Operation
- **States:** ENTRY, OPEN, FAIL, LOCKOUT. All outputs are registered, with no combinational path from inputs to outputs.
- **Reset values:**
  - State = ENTRY.
  - `unlocked` = `wrong` = `locked_out` = 0.
  - `digit_count` = 0.
  - `attempts_left` = MAX_TRIES.
  - Internal `code_q` = 0 and `mismatch` = 0.
- **Entering digits (ENTRY state):**
  - `enter` with `digit_count` = 0 latches `code` into `code_q`. Later changes on `code` have no effect on this entry.
  - Each `enter` compares `digit` against slice `code_q[7-2n:6-2n]`, where n = `digit_count`. For n = 0 the comparison uses the live `code` value being latched.
  - A miscompare sets the sticky `mismatch` flag.
  - Each `enter` increments `digit_count`.
- **Fourth digit** (`enter` with `digit_count` = 3):
  - If there is no mismatch, including the 4th digit: go to OPEN.
  - Otherwise, if `attempts_left` > 1: go to FAIL and decrement `attempts_left`.
  - Otherwise: go to LOCKOUT and set `attempts_left` = 0.
  - `digit_count` shows 4 for the entire time the block is in OPEN, FAIL or LOCKOUT.
- **`clear` in ENTRY:** `digit_count` → 0 and `mismatch` → 0. This does not consume an attempt.
- **OPEN:**
  - `unlocked` = 1 until `clear`.
  - `clear` → ENTRY, `digit_count` = 0, `attempts_left` = MAX_TRIES.
  - `enter` is ignored.
- **FAIL:**
  - `wrong` = 1 for exactly FAIL_CYCLES cycles, then → ENTRY with `digit_count` = 0.
  - `enter` and `clear` are ignored.
- **LOCKOUT:**
  - `locked_out` = 1 for exactly LOCKOUT_CYCLES cycles, then → ENTRY with `digit_count` = 0 and `attempts_left` = MAX_TRIES.
  - `enter` and `clear` are ignored.
- **Shared timer:** a single down-counter serves both FAIL and LOCKOUT. It must be wide enough for max(FAIL_CYCLES, LOCKOUT_CYCLES).

## Timing
- **Latency:** an `enter` sampled at edge k updates `digit_count` and the state at edge k. New output values are visible in the cycle after edge k.
- **Dwell times:** `wrong` is high for exactly FAIL_CYCLES consecutive cycles and `locked_out` for exactly LOCKOUT_CYCLES. ENTRY resumes in the following cycle.
- **Simultaneous `enter` and `clear` in ENTRY:** `clear` wins and the digit is discarded.
- **Back-to-back `enter` pulses** on consecutive cycles are all accepted.
- **`reset` asserted mid-entry or mid-timer:** everything returns to reset values immediately, regardless of the clock.
- **Upstream code regenerated while `reset` is high:** after `reset` falls, the first `enter` latches the new code.

## Test plan
Use `code` = 8'b10_01_11_00, i.e. digits 2,1,3,0.
- **Correct code:** reset, then `enter` 2,1,3,0. `unlocked` = 1 the cycle after the 4th `enter`, `digit_count` = 4, `attempts_left` = 3. Then `clear`: `unlocked` = 0, `digit_count` = 0.
- **Single wrong code:** `enter` 2,1,3,1. `wrong` is high for exactly 20 cycles, `attempts_left` = 2, `digit_count` returns to 0. Then `enter` 2,1,3,0 unlocks.
- **Lockout:** three wrong entries. The third goes directly to LOCKOUT: `locked_out` is high for 100 cycles with `attempts_left` = 0. `enter` pulses during lockout have no effect. Afterwards `attempts_left` = 3.
- **Clear mid-entry:** `enter` 2,1, then `clear`. `digit_count` = 0 and `attempts_left` stays 3. Then `enter` 2,1,3,0 unlocks. Also drive `enter` and `clear` in the same cycle: `digit_count` stays 0.
- **Code latched on first digit:** change `code` to 8'hFF after the first `enter`. Entry 2,1,3,0 still unlocks.
- **Async reset:** assert `reset` between clock edges during FAIL. All outputs return to reset values before the next edge.
